bidi_bus_ctrl: RTL and testbench

// Half-duplex controller for a DW-bit bank of inferred bidi pad cells. It owns each
//   pad's drive-enable (pad_t, 0 = drive), drive data (pad_i) and sampled input (pad_o).
// It converts single-beat write/read requests from core logic into pad sequences,
//   and enforces turnaround idle cycles whenever bus direction changes.

---
 rtl/bidi_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_bidi_bus_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bidi_bus_ctrl.sv
// Half-duplex pad-bank controller: turns single-beat write/read requests into
// pad drive/sample sequences and inserts turnaround cycles on direction changes.
module bidi_bus_ctrl #(
    parameter int DW     = 8,
    parameter int TURN   = 2,
    parameter int WR_CYC = 1,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [DW-1:0] pad_t,
    output logic [DW-1:0] pad_i,
    input  logic [DW-1:0] pad_o,
    output logic          bus_dir
);

    if (TURN < 1 || TURN > 15) begin : g_bad_turn
        $error("bidi_bus_ctrl: TURN must be 1..15");
    end
    if (WR_CYC < 1 || WR_CYC > 15) begin : g_bad_wr_cyc
        $error("bidi_bus_ctrl: WR_CYC must be 1..15");
    end
    if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
        $error("bidi_bus_ctrl: SETTLE must be 2..15");
    end

    localparam logic [3:0] TURN_LD   = 4'(TURN - 1);
    localparam logic [3:0] WR_LD     = 4'(WR_CYC - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_WRITE, S_READ} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_dir_q, last_dir_d;  // 1 = last transfer was a write
    logic          pend_wr_q, pend_wr_d;
    logic          drive_q, drive_d;
    logic [DW-1:0] pad_i_q, pad_i_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DW-1:0] o_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_dir_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            drive_q     <= 1'b0;
            pad_i_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            o_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dir_q  <= last_dir_d;
            pend_wr_q   <= pend_wr_d;
            drive_q     <= drive_d;
            pad_i_q     <= pad_i_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            o_q         <= pad_o;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dir_d  = last_dir_q;
        pend_wr_d   = pend_wr_q;
        drive_d     = drive_q;
        pad_i_d     = pad_i_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                // Idle parks the bus in whatever direction the last transfer left it.
                if (req_valid) begin
                    pend_wr_d = req_wr;
                    if (req_wr) pad_i_d = req_wdata;
                    if (req_wr != last_dir_q) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LD;
                        drive_d = 1'b0;
                    end else if (req_wr) begin
                        state_d = S_WRITE;
                        cnt_d   = WR_LD;
                        drive_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = SETTLE_LD;
                        drive_d = 1'b0;
                    end
                end
            end
            S_TURN: begin
                drive_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    if (pend_wr_q) begin
                        state_d = S_WRITE;
                        cnt_d   = WR_LD;
                        drive_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = SETTLE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                drive_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d    = S_IDLE;
                    last_dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READ: begin
                drive_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d     = S_IDLE;
                    last_dir_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = o_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) & ~reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign pad_t     = {DW{~drive_q}};
    assign pad_i     = pad_i_q;
    assign bus_dir   = drive_q;

endmodule

// File: tb/tb_bidi_bus_ctrl.sv
// Directed bench for bidi_bus_ctrl: cycle-by-cycle pad checks plus a read-data
// scoreboard fed at request time and drained on each rsp_valid pulse.
module tb_bidi_bus_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [DW-1:0] pad_t;
    logic [DW-1:0] pad_i;
    logic [DW-1:0] pad_o;
    logic          bus_dir;

    int tests  = 0;
    int failed = 0;
    int rsp_seen = 0;
    logic [DW-1:0] exp_q[$];

    bidi_bus_ctrl #(.DW(DW), .TURN(2), .WR_CYC(1), .SETTLE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .pad_t     (pad_t),
        .pad_i     (pad_i),
        .pad_o     (pad_o),
        .bus_dir   (bus_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic do_req(input logic wr, input logic [DW-1:0] data);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_wdata = data;
        if (!wr) exp_q.push_back(pad_o);
        tick();
        req_valid = 1'b0;
        req_wdata = '0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && rsp_valid === 1'b1) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_data", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_wdata = '0;
        pad_o     = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_pad_t", {24'd0, pad_t}, 32'hFF);
        check("rst_pad_i", {24'd0, pad_i}, 32'h00);
        check("rst_bus_dir", {31'd0, bus_dir}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Write A5 from reset: two turnaround cycles, then one drive cycle
        do_req(1'b1, 8'hA5);
        check("w1_c1_pad_t", {24'd0, pad_t}, 32'hFF);
        tick();
        check("w1_c2_pad_t", {24'd0, pad_t}, 32'hFF);
        check("w1_c2_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("w1_c3_pad_t", {24'd0, pad_t}, 32'h00);
        check("w1_c3_pad_i", {24'd0, pad_i}, 32'hA5);
        check("w1_c3_bus_dir", {31'd0, bus_dir}, 32'd1);
        tick();
        check("w1_c4_ready", {31'd0, req_ready}, 32'd1);
        check("w1_park_pad_t", {24'd0, pad_t}, 32'h00);
        check("w1_park_pad_i", {24'd0, pad_i}, 32'hA5);

        // Back-to-back write: no turnaround, bus stays driven
        do_req(1'b1, 8'h3C);
        check("w2_c1_pad_t", {24'd0, pad_t}, 32'h00);
        check("w2_c1_pad_i", {24'd0, pad_i}, 32'h3C);
        tick();
        check("w2_c2_ready", {31'd0, req_ready}, 32'd1);
        check("w2_c2_pad_t", {24'd0, pad_t}, 32'h00);

        // Read after write: 2 turn + 2 settle cycles; pad_o changes after the sample edge
        pad_o = 8'h5A;
        do_req(1'b0, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            check("r1_pad_t", {24'd0, pad_t}, 32'hFF);
            check("r1_rsp_idle", {31'd0, rsp_valid}, 32'd0);
            if (c == 4) pad_o = 8'hEE;
            tick();
        end
        check("r1_c5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("r1_c5_rdata", {24'd0, rsp_rdata}, 32'h5A);
        check("r1_c5_ready", {31'd0, req_ready}, 32'd1);

        // Read then read: no turnaround, response in cycle 3
        pad_o = 8'h11;
        do_req(1'b0, 8'h00);
        check("r2_c1_pad_t", {24'd0, pad_t}, 32'hFF);
        tick();
        check("r2_c2_rsp_idle", {31'd0, rsp_valid}, 32'd0);
        check("r2_c2_rdata_hold", {24'd0, rsp_rdata}, 32'h5A);
        pad_o = 8'h99;
        tick();
        check("r2_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("r2_c3_rdata", {24'd0, rsp_rdata}, 32'h11);

        pad_o = 8'h22;
        do_req(1'b0, 8'h00);
        tick();
        check("r3_c2_rsp_idle", {31'd0, rsp_valid}, 32'd0);
        pad_o = 8'h99;
        tick();
        check("r3_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("r3_c3_rdata", {24'd0, rsp_rdata}, 32'h22);

        // Reset during the drive cycle of a write
        do_req(1'b1, 8'h77);
        check("w3_c1_pad_t", {24'd0, pad_t}, 32'hFF);
        tick();
        tick();
        check("w3_c3_pad_t", {24'd0, pad_t}, 32'h00);
        check("w3_c3_pad_i", {24'd0, pad_i}, 32'h77);
        reset = 1'b1;
        #1;
        check("mid_rst_pad_t", {24'd0, pad_t}, 32'hFF);
        check("mid_rst_bus_dir", {31'd0, bus_dir}, 32'd0);
        check("mid_rst_pad_i", {24'd0, pad_i}, 32'h00);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);

        // Write after reset re-incurs turnaround
        do_req(1'b1, 8'h0F);
        check("w4_c1_pad_t", {24'd0, pad_t}, 32'hFF);
        tick();
        check("w4_c2_pad_t", {24'd0, pad_t}, 32'hFF);
        tick();
        check("w4_c3_pad_t", {24'd0, pad_t}, 32'h00);
        check("w4_c3_pad_i", {24'd0, pad_i}, 32'h0F);
        tick();
        check("w4_c4_ready", {31'd0, req_ready}, 32'd1);

        repeat (2) tick();
        check("sb_drained", exp_q.size(), 32'd0);
        check("rsp_count", rsp_seen, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
